ring_seq_ctrl: RTL

- Sequencer for the 10-stage ring counter datapath and its N-bit enabled source counter.
- Drives ring shift/mode/reset and counter enable/reset through one full pass: clear, fill, mode-0 run, mode-1 run, done.
- Sits beside the ring and counter and replaces hand-driven shift/mode stimulus.
- Start/done handshake toward the system, plus pause and abort.

---
 rtl/ring_seq_pkg.sv | 15 +
 rtl/ring_seq_timer.sv | 29 ++
 rtl/ring_seq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ring_seq_pkg.sv
// Shared state encoding for the ring sequencer.
package ring_seq_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN0  = 3'd3,
    ST_RUN1  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ring_seq_timer.sv
// Phase counter: counts enabled cycles, raises tc on the last cycle of a
// phase of length len, and wraps to zero when that cycle is taken.
module ring_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == (len - CNT_W'(1)));

  // Counter: clear has priority, wrap on terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ring_seq_ctrl.sv
// Ring/source-counter pass sequencer: clear, fill, mode-0 run, mode-1 run, done.
// Optional pass counter output enabled by defining RING_SEQ_PASS_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle of ring and counter reset
// FILL  | DEPTH shift cycles loading the ring
// RUN0  | LEN0 shift cycles, mode 0
// RUN1  | LEN1 shift cycles, mode 1
// DONE  | one-cycle completion pulse; loop restarts via CLEAR
module ring_seq_ctrl
  import ring_seq_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int LEN0  = 256,
  parameter int LEN1  = 128,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic               loop,
  output logic               shift,
  output logic               mode,
  output logic               ring_reset_n,
  output logic               cnt_reset_n,
  output logic               cnt_enb,
  output logic               busy,
  output logic               done,
  output logic               ring_valid,
  output logic [PHASE_W-1:0] phase
`ifdef RING_SEQ_PASS_CNT_EN
  ,
  output logic [15:0]        pass_cnt
`endif
);

  state_t           state_q, state_d;
  logic             paused_q;
  logic             active;
  logic             shift_cyc;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_len;

  // State register and one-cycle-delayed pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= pause;
    end
  end

  // Timer control: run only on unpaused active cycles, length chosen by phase.
  always_comb begin
    active    = (state_q == ST_FILL) || (state_q == ST_RUN0) || (state_q == ST_RUN1);
    shift_cyc = active && !paused_q;
    tmr_clr   = !active || abort;
    case (state_q)
      ST_RUN0: tmr_len = CNT_W'(LEN0);
      ST_RUN1: tmr_len = CNT_W'(LEN1);
      default: tmr_len = CNT_W'(DEPTH);
    endcase
  end

  ring_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (shift_cyc),
    .len   (tmr_len),
    .tc    (tmr_tc)
  );

  // Next state: abort beats everything, pause stalls the phase advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !abort) state_d = ST_CLEAR;
      ST_CLEAR: state_d = abort ? ST_IDLE : ST_FILL;
      ST_FILL: begin
        if (abort)                  state_d = ST_IDLE;
        else if (shift_cyc && tmr_tc) state_d = ST_RUN0;
      end
      ST_RUN0: begin
        if (abort)                  state_d = ST_IDLE;
        else if (shift_cyc && tmr_tc) state_d = ST_RUN1;
      end
      ST_RUN1: begin
        if (abort)                  state_d = ST_IDLE;
        else if (shift_cyc && tmr_tc) state_d = ST_DONE;
      end
      ST_DONE:  state_d = (loop && !abort) ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; the resets also follow the chip reset so they are low during it.
  always_comb begin
    shift        = shift_cyc;
    cnt_enb      = shift_cyc;
    mode         = (state_q == ST_RUN1);
    ring_reset_n = reset && (state_q != ST_CLEAR);
    cnt_reset_n  = reset && (state_q != ST_CLEAR);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    ring_valid   = (state_q == ST_RUN0) || (state_q == ST_RUN1) || (state_q == ST_DONE);
    phase        = state_q;
  end

`ifdef RING_SEQ_PASS_CNT_EN
  // Completed-pass counter; survives abort, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt <= 16'd0;
    end else if (state_q == ST_DONE) begin
      pass_cnt <= pass_cnt + 16'd1;
    end
  end
`endif

endmodule
